dds_par_slave: RTL and testbench
================================

DDS_PAR_SLAVE -- requirements
Module: dds_par_slave

Interface
REQ-001 SHALL have parameter NREG, default 41, number of implemented byte registers at addresses 0x00..NREG-1.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port mst_rst  input  1  bus master reset, asynchronous to clk, active high.
REQ-005 SHALL have port d  input  8  bus write data.
REQ-006 SHALL have port a  input  6  bus write address.
REQ-007 SHALL have port wrb  input  1  bus write strobe; a/d are captured on its rising edge.
REQ-008 SHALL have port io_ud  input  1  bus update; a rising edge copies shadow to active.
REQ-009 SHALL have port ftw1  output  48  active bytes 0x04..0x09; 0x04 is the MSB.
REQ-010 SHALL have port ctrl  output  32  active bytes 0x1D..0x20; 0x1D is the MSB.
REQ-011 SHALL have port upd_pulse  output  1  one-cycle pulse per accepted update.
REQ-012 SHALL have port wr_err  output  1  sticky flag: write to an address >= NREG.
REQ-013 SHALL have port wr_cnt  output  8  count of accepted writes; wraps 255->0.

Function
REQ-014 SHALL pass wrb, io_ud and mst_rst each through a two-flop synchronizer, then a rising-edge detector.
REQ-015 SHALL pass a and d through the same two-flop delay, so they stay aligned with synchronized wrb.
REQ-016 On a detected wrb rise, SHALL write d into shadow[a] in that same cycle: latency 3 clk from the bus edge.
- Bus requirement: a/d stable >=3 clk either side of the wrb rise.
REQ-017 SHALL ignore writes with a >= NREG, set wr_err, and leave wr_cnt unchanged; valid writes SHALL increment wr_cnt.
REQ-018 On a detected io_ud rise, SHALL copy every shadow byte to active and assert upd_pulse for exactly one cycle.
REQ-019 If a write and an update are detected in the same cycle, active SHALL receive the newly written value.
REQ-020 While synchronized mst_rst is high, the block SHALL:
- load shadow and active with defaults;
- clear wr_cnt and wr_err;
- suppress writes, updates and upd_pulse.
REQ-021 Defaults SHALL be:
- 0x1D=0x10, 0x1E=0x64, 0x1F=0x01, 0x20=0x20;
- all other bytes 0x00.
REQ-022 A level held high on wrb or io_ud SHALL NOT retrigger; only rising edges act.
REQ-023 ftw1 and ctrl SHALL be driven directly from active registers, with no added latency.

Reset
REQ-024 rst SHALL asynchronously do all of the following:
- force synchronizer flops to 0;
- load shadow and active with the REQ-021 defaults;
- clear wr_cnt, wr_err and upd_pulse.
REQ-025 After rst deasserts, a bus level already high SHALL NOT be seen as an edge.

Configuration
REQ-026 With DDS_SLV_READBACK_EN defined, the block SHALL add the following ports:
- rd_addr  input  6;
- rd_sel  input  1;
- rd_data  output  8.
REQ-027 rd_data SHALL give active[rd_addr] when rd_sel=1, or shadow[rd_addr] when rd_sel=0, registered with 1-clk latency, and 0x00 for out-of-range addresses.
REQ-028 Without DDS_SLV_READBACK_EN, these ports and their logic SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-029 Package dds_slv_pkg SHALL hold:
- address constants FTW1_BASE=0x04 and CTRL_BASE=0x1D;
- the default-value table;
- data and address widths.
REQ-030 Sub-module dds_sync2 SHALL implement one 2-flop synchronizer plus a rising-edge pulse; it is instantiated for wrb, io_ud and mst_rst.

Verification
REQ-031 Write 0x04..0x09 = 0C,CC,CC,CC,CC,CC with no io_ud -> ftw1 stays 0; pulse io_ud -> ftw1=0x0CCCCCCCCCCC one cycle after the detected edge; upd_pulse high 1 clk.
REQ-032 Write 0x1D..0x20 = 10,45,00,40, then io_ud -> ctrl=0x10450040; wr_cnt=4.
REQ-033 Write and io_ud edges coincide after sync, writing 0x09=0xAA -> ftw1[7:0]=0xAA in the same update.
REQ-034 Write a=0x30 with d=0x55 -> wr_err=1, wr_cnt unchanged, no register changed.
REQ-035 Pulse mst_rst mid-sequence after a write to 0x04 -> ctrl=0x10640120, ftw1=0, wr_cnt=0; wrb edges while mst_rst is high are ignored.
REQ-036 Assert rst while wrb and io_ud are high, then release -> no write and no upd_pulse until each signal falls and rises again.

Source files
------------

// File: rtl/dds_slv_pkg.sv
// rtl/dds_slv_pkg.sv - widths, register map constants and power-on defaults for dds_par_slave
package dds_slv_pkg;

    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 6;
    localparam int FTW1_BYTES = 6;
    localparam int CTRL_BYTES = 4;

    localparam logic [ADDR_W-1:0] FTW1_BASE = 6'h04;
    localparam logic [ADDR_W-1:0] CTRL_BASE = 6'h1D;

    // Default-value table: only the control word has non-zero reset contents.
    function automatic logic [DATA_W-1:0] dflt_byte(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        case (addr)
            CTRL_BASE:         val = 8'h10;
            CTRL_BASE + 6'd1:  val = 8'h64;
            CTRL_BASE + 6'd2:  val = 8'h01;
            CTRL_BASE + 6'd3:  val = 8'h20;
            default:           val = 8'h00;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/dds_sync2.sv
// rtl/dds_sync2.sv - two-flop synchronizer followed by a rising-edge pulse
module dds_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic lvl,
    output logic rise
);

    logic       s1_q, s1_d;
    logic       s2_q, s2_d;
    logic       hist_q, hist_d;
    logic [1:0] vld_q, vld_d;

    always_comb begin
        s1_d  = din;
        s2_d  = s1_q;
        vld_d = {vld_q[0], 1'b1};
        // History reads high until s2 holds a genuine sample, so a level
        // already high when reset is released never looks like an edge.
        hist_d = vld_q[1] ? s2_q : 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            hist_q <= 1'b1;
            vld_q  <= 2'b00;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            hist_q <= hist_d;
            vld_q  <= vld_d;
        end
    end

    assign lvl  = s2_q;
    assign rise = s2_q & ~hist_q;

endmodule

// File: rtl/dds_par_slave.sv
// rtl/dds_par_slave.sv - parallel-bus shadow/active register slave; DDS_SLV_READBACK_EN adds a read port
module dds_par_slave
    import dds_slv_pkg::*;
#(
    parameter int NREG = 41
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mst_rst,
    input  logic [DATA_W-1:0]       d,
    input  logic [ADDR_W-1:0]       a,
    input  logic                    wrb,
    input  logic                    io_ud,
`ifdef DDS_SLV_READBACK_EN
    input  logic [ADDR_W-1:0]       rd_addr,
    input  logic                    rd_sel,
    output logic [DATA_W-1:0]       rd_data,
`endif
    output logic [8*FTW1_BYTES-1:0] ftw1,
    output logic [8*CTRL_BYTES-1:0] ctrl,
    output logic                    upd_pulse,
    output logic                    wr_err,
    output logic [7:0]              wr_cnt
);

    logic wr_rise, ud_rise, mst_lvl;
    logic wrb_lvl, ud_lvl, mst_rise;
    logic unused_sync;

    dds_sync2 u_wrb_sync (.clk(clk), .rst(rst), .din(wrb),     .lvl(wrb_lvl), .rise(wr_rise));
    dds_sync2 u_ud_sync  (.clk(clk), .rst(rst), .din(io_ud),   .lvl(ud_lvl),  .rise(ud_rise));
    dds_sync2 u_mst_sync (.clk(clk), .rst(rst), .din(mst_rst), .lvl(mst_lvl), .rise(mst_rise));

    assign unused_sync = wrb_lvl ^ ud_lvl ^ mst_rise;

    logic [ADDR_W-1:0] a_s1_q, a_s1_d, a_s2_q, a_s2_d;
    logic [DATA_W-1:0] d_s1_q, d_s1_d, d_s2_q, d_s2_d;
    logic [DATA_W-1:0] shadow_q [NREG];
    logic [DATA_W-1:0] shadow_d [NREG];
    logic [DATA_W-1:0] active_q [NREG];
    logic [DATA_W-1:0] active_d [NREG];
    logic [7:0]        wr_cnt_q, wr_cnt_d;
    logic              wr_err_q, wr_err_d;
    logic              upd_pulse_q, upd_pulse_d;
    logic              addr_ok;

    assign addr_ok = (int'(a_s2_q) < NREG);

    always_comb begin
        a_s1_d      = a;
        a_s2_d      = a_s1_q;
        d_s1_d      = d;
        d_s2_d      = d_s1_q;
        shadow_d    = shadow_q;
        active_d    = active_q;
        wr_cnt_d    = wr_cnt_q;
        wr_err_d    = wr_err_q;
        upd_pulse_d = 1'b0;

        if (mst_lvl) begin
            for (int i = 0; i < NREG; i++) begin
                shadow_d[i] = dflt_byte(ADDR_W'(i));
                active_d[i] = dflt_byte(ADDR_W'(i));
            end
            wr_cnt_d = '0;
            wr_err_d = 1'b0;
        end else begin
            if (wr_rise) begin
                if (addr_ok) begin
                    for (int i = 0; i < NREG; i++) begin
                        if (a_s2_q == ADDR_W'(i)) begin
                            shadow_d[i] = d_s2_q;
                        end
                    end
                    wr_cnt_d = wr_cnt_q + 8'd1;
                end else begin
                    wr_err_d = 1'b1;
                end
            end
            // Copying from shadow_d lets a coincident write land in active too.
            if (ud_rise) begin
                active_d    = shadow_d;
                upd_pulse_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_s1_q      <= '0;
            a_s2_q      <= '0;
            d_s1_q      <= '0;
            d_s2_q      <= '0;
            for (int i = 0; i < NREG; i++) begin
                shadow_q[i] <= dflt_byte(ADDR_W'(i));
                active_q[i] <= dflt_byte(ADDR_W'(i));
            end
            wr_cnt_q    <= '0;
            wr_err_q    <= 1'b0;
            upd_pulse_q <= 1'b0;
        end else begin
            a_s1_q      <= a_s1_d;
            a_s2_q      <= a_s2_d;
            d_s1_q      <= d_s1_d;
            d_s2_q      <= d_s2_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            wr_cnt_q    <= wr_cnt_d;
            wr_err_q    <= wr_err_d;
            upd_pulse_q <= upd_pulse_d;
        end
    end

    assign ftw1 = {active_q[FTW1_BASE],        active_q[FTW1_BASE + 6'd1],
                   active_q[FTW1_BASE + 6'd2], active_q[FTW1_BASE + 6'd3],
                   active_q[FTW1_BASE + 6'd4], active_q[FTW1_BASE + 6'd5]};
    assign ctrl = {active_q[CTRL_BASE],        active_q[CTRL_BASE + 6'd1],
                   active_q[CTRL_BASE + 6'd2], active_q[CTRL_BASE + 6'd3]};

    assign upd_pulse = upd_pulse_q;
    assign wr_err    = wr_err_q;
    assign wr_cnt    = wr_cnt_q;

`ifdef DDS_SLV_READBACK_EN
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < NREG; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                rd_data_d = rd_sel ? active_q[i] : shadow_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_dds_par_slave.sv
// tb/tb_dds_par_slave.sv - randomized self-checking bench for dds_par_slave against a register-map model
module tb_dds_par_slave;

    localparam int NREG = 41;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mst_rst = 1'b0;
    logic [7:0]  d = 8'h00;
    logic [5:0]  a = 6'h00;
    logic        wrb = 1'b0;
    logic        io_ud = 1'b0;
    logic [47:0] ftw1;
    logic [31:0] ctrl;
    logic        upd_pulse;
    logic        wr_err;
    logic [7:0]  wr_cnt;
`ifdef DDS_SLV_READBACK_EN
    logic [5:0]  rd_addr = 6'h00;
    logic        rd_sel = 1'b0;
    logic [7:0]  rd_data;
`endif

    int checks = 0;
    int passed = 0;

    logic [7:0] sh_m  [64];
    logic [7:0] act_m [64];
    logic [7:0] cnt_m;
    logic       err_m;

    always #5 clk = ~clk;

    dds_par_slave #(.NREG(NREG)) dut (
        .clk(clk), .rst(rst), .mst_rst(mst_rst), .d(d), .a(a), .wrb(wrb), .io_ud(io_ud),
`ifdef DDS_SLV_READBACK_EN
        .rd_addr(rd_addr), .rd_sel(rd_sel), .rd_data(rd_data),
`endif
        .ftw1(ftw1), .ctrl(ctrl), .upd_pulse(upd_pulse), .wr_err(wr_err), .wr_cnt(wr_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_defaults();
        for (int i = 0; i < 64; i++) begin
            sh_m[i]  = 8'h00;
            act_m[i] = 8'h00;
        end
        sh_m[29] = 8'h10; sh_m[30] = 8'h64; sh_m[31] = 8'h01; sh_m[32] = 8'h20;
        act_m[29] = 8'h10; act_m[30] = 8'h64; act_m[31] = 8'h01; act_m[32] = 8'h20;
        cnt_m = 8'd0;
        err_m = 1'b0;
    endfunction

    function automatic void model_write(input int addr, input logic [7:0] data);
        if (addr < NREG) begin
            sh_m[addr] = data;
            cnt_m = cnt_m + 8'd1;
        end else begin
            err_m = 1'b1;
        end
    endfunction

    function automatic void model_update();
        for (int i = 0; i < 64; i++) act_m[i] = sh_m[i];
    endfunction

    function automatic logic [47:0] exp_ftw();
        logic [47:0] v = 48'h0;
        for (int k = 0; k < 6; k++) v = v * 256 + 48'(act_m[4 + k]);
        return v;
    endfunction

    function automatic logic [31:0] exp_ctrl();
        logic [31:0] v = 32'h0;
        for (int k = 0; k < 4; k++) v = v * 256 + 32'(act_m[29 + k]);
        return v;
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        model_defaults();
        repeat (3) tick();
    endtask

    task automatic bus_write(input logic [5:0] addr, input logic [7:0] data);
        a = addr;
        d = data;
        repeat (3) tick();
        wrb = 1'b1;
        repeat (4) tick();
        wrb = 1'b0;
        repeat (3) tick();
    endtask

    task automatic bus_update(output int pulses);
        pulses = 0;
        io_ud = 1'b1;
        repeat (4) begin tick(); if (upd_pulse === 1'b1) pulses++; end
        io_ud = 1'b0;
        repeat (3) begin tick(); if (upd_pulse === 1'b1) pulses++; end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (ftw1 !== 48'h0) $display("FAIL reset_ftw1 got=%h exp=%h", ftw1, 48'h0); else passed++;
        checks++; if (ctrl !== 32'h10640120) $display("FAIL reset_ctrl got=%h exp=%h", ctrl, 32'h10640120); else passed++;
        checks++; if (wr_cnt !== 8'd0) $display("FAIL reset_cnt got=%h exp=%h", wr_cnt, 8'd0); else passed++;
        checks++; if (wr_err !== 1'b0) $display("FAIL reset_err got=%b exp=0", wr_err); else passed++;
        checks++; if (upd_pulse !== 1'b0) $display("FAIL reset_pulse got=%b exp=0", upd_pulse); else passed++;
    endtask

    task automatic test_ftw_update();
        logic [7:0] bytes [6] = '{8'h0C, 8'hCC, 8'hCC, 8'hCC, 8'hCC, 8'hCC};
        for (int k = 0; k < 6; k++) begin
            bus_write(6'(4 + k), bytes[k]);
            model_write(4 + k, bytes[k]);
        end
        checks++; if (ftw1 !== 48'h0) $display("FAIL ftw_no_update got=%h exp=%h", ftw1, 48'h0); else passed++;
        io_ud = 1'b1;
        repeat (2) tick();
        checks++; if (ftw1 !== 48'h0 || upd_pulse !== 1'b0)
            $display("FAIL ftw_early got=%h/%b exp=%h/0", ftw1, upd_pulse, 48'h0); else passed++;
        tick();
        model_update();
        checks++; if (ftw1 !== 48'h0CCCCCCCCCCC) $display("FAIL ftw_value got=%h exp=%h", ftw1, 48'h0CCCCCCCCCCC); else passed++;
        checks++; if (ftw1 !== exp_ftw()) $display("FAIL ftw_model got=%h exp=%h", ftw1, exp_ftw()); else passed++;
        checks++; if (upd_pulse !== 1'b1) $display("FAIL ftw_pulse_on got=%b exp=1", upd_pulse); else passed++;
        tick();
        checks++; if (upd_pulse !== 1'b0) $display("FAIL ftw_pulse_off got=%b exp=0", upd_pulse); else passed++;
        io_ud = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_ctrl();
        logic [7:0] bytes [4] = '{8'h10, 8'h45, 8'h00, 8'h40};
        int p;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            bus_write(6'(29 + k), bytes[k]);
            model_write(29 + k, bytes[k]);
        end
        bus_update(p);
        model_update();
        checks++; if (ctrl !== 32'h10450040) $display("FAIL ctrl_value got=%h exp=%h", ctrl, 32'h10450040); else passed++;
        checks++; if (ctrl !== exp_ctrl()) $display("FAIL ctrl_model got=%h exp=%h", ctrl, exp_ctrl()); else passed++;
        checks++; if (wr_cnt !== 8'd4) $display("FAIL ctrl_cnt got=%0d exp=4", wr_cnt); else passed++;
        checks++; if (p != 1) $display("FAIL ctrl_pulses got=%0d exp=1", p); else passed++;
    endtask

    task automatic test_coincide();
        a = 6'h09;
        d = 8'hAA;
        repeat (3) tick();
        wrb = 1'b1;
        io_ud = 1'b1;
        repeat (3) tick();
        model_write(9, 8'hAA);
        model_update();
        checks++; if (ftw1[7:0] !== 8'hAA) $display("FAIL coincide_byte got=%h exp=%h", ftw1[7:0], 8'hAA); else passed++;
        checks++; if (ftw1 !== exp_ftw()) $display("FAIL coincide_ftw got=%h exp=%h", ftw1, exp_ftw()); else passed++;
        checks++; if (upd_pulse !== 1'b1) $display("FAIL coincide_pulse got=%b exp=1", upd_pulse); else passed++;
        tick();
        wrb = 1'b0;
        io_ud = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_bad_addr();
        int p;
        logic [7:0] cnt0;
        logic [47:0] f0;
        logic [31:0] c0;
        cnt0 = wr_cnt;
        f0 = ftw1;
        c0 = ctrl;
        bus_write(6'h30, 8'h55);
        model_write(48, 8'h55);
        checks++; if (wr_err !== 1'b1) $display("FAIL bad_err got=%b exp=1", wr_err); else passed++;
        checks++; if (wr_cnt !== cnt_m) $display("FAIL bad_cnt got=%0d exp=%0d", wr_cnt, cnt_m); else passed++;
        bus_write(6'(NREG), 8'h66);
        model_write(NREG, 8'h66);
        checks++; if (wr_cnt !== cnt_m) $display("FAIL nreg_cnt got=%0d exp=%0d", wr_cnt, cnt_m); else passed++;
        bus_write(6'(NREG - 1), 8'h77);
        model_write(NREG - 1, 8'h77);
        checks++; if (wr_cnt !== cnt_m) $display("FAIL last_cnt got=%0d exp=%0d", wr_cnt, cnt_m); else passed++;
        checks++; if (wr_cnt !== cnt0 + 8'd1) $display("FAIL last_inc got=%0d exp=%0d", wr_cnt, cnt0 + 8'd1); else passed++;
        bus_update(p);
        model_update();
        checks++; if (ftw1 !== f0 || ctrl !== c0)
            $display("FAIL bad_unchanged got=%h/%h exp=%h/%h", ftw1, ctrl, f0, c0); else passed++;
        checks++; if (wr_err !== 1'b1) $display("FAIL bad_sticky got=%b exp=1", wr_err); else passed++;
    endtask

    task automatic test_mst_rst();
        int p;
        bus_write(6'h04, 8'h5A);
        model_write(4, 8'h5A);
        bus_update(p);
        model_update();
        bus_write(6'h3F, 8'h01);
        model_write(63, 8'h01);
        checks++; if (ftw1 !== exp_ftw()) $display("FAIL mst_pre_ftw got=%h exp=%h", ftw1, exp_ftw()); else passed++;
        mst_rst = 1'b1;
        repeat (4) tick();
        model_defaults();
        checks++; if (ftw1 !== 48'h0) $display("FAIL mst_held_ftw got=%h exp=%h", ftw1, 48'h0); else passed++;
        bus_write(6'h04, 8'h33);
        bus_update(p);
        checks++; if (p != 0) $display("FAIL mst_pulses got=%0d exp=0", p); else passed++;
        mst_rst = 1'b0;
        repeat (4) tick();
        bus_update(p);
        checks++; if (ctrl !== 32'h10640120) $display("FAIL mst_ctrl got=%h exp=%h", ctrl, 32'h10640120); else passed++;
        checks++; if (ftw1 !== 48'h0) $display("FAIL mst_ftw got=%h exp=%h", ftw1, 48'h0); else passed++;
        checks++; if (wr_cnt !== 8'd0) $display("FAIL mst_cnt got=%0d exp=0", wr_cnt); else passed++;
        checks++; if (wr_err !== 1'b0) $display("FAIL mst_err got=%b exp=0", wr_err); else passed++;
    endtask

    task automatic test_rst_held_high();
        int p;
        int seen;
        a = 6'h04;
        d = 8'h77;
        wrb = 1'b1;
        io_ud = 1'b1;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        model_defaults();
        seen = 0;
        repeat (10) begin tick(); if (upd_pulse === 1'b1) seen++; end
        checks++; if (seen != 0) $display("FAIL held_pulses got=%0d exp=0", seen); else passed++;
        checks++; if (wr_cnt !== 8'd0) $display("FAIL held_cnt got=%0d exp=0", wr_cnt); else passed++;
        wrb = 1'b0;
        io_ud = 1'b0;
        repeat (3) tick();
        bus_update(p);
        model_update();
        checks++; if (p != 1) $display("FAIL held_rearm got=%0d exp=1", p); else passed++;
        checks++; if (ftw1 !== exp_ftw()) $display("FAIL held_ftw got=%h exp=%h", ftw1, exp_ftw()); else passed++;
        bus_write(6'h04, 8'h77);
        model_write(4, 8'h77);
        bus_update(p);
        model_update();
        checks++; if (ftw1 !== 48'h770000000000) $display("FAIL held_resume got=%h exp=%h", ftw1, 48'h770000000000); else passed++;
    endtask

    task automatic test_cnt_wrap();
        apply_reset();
        for (int k = 0; k < 255; k++) begin
            bus_write(6'h00, 8'(k));
            model_write(0, 8'(k));
        end
        checks++; if (wr_cnt !== 8'd255) $display("FAIL wrap_255 got=%0d exp=255", wr_cnt); else passed++;
        bus_write(6'h01, 8'hFF);
        model_write(1, 8'hFF);
        checks++; if (wr_cnt !== 8'd0 || wr_cnt !== cnt_m) $display("FAIL wrap_0 got=%0d exp=%0d", wr_cnt, cnt_m); else passed++;
    endtask

    task automatic test_random();
        int p;
        int sel;
        logic [5:0] addr;
        logic [7:0] data;
        apply_reset();
        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(0, 4);
            if (sel == 0) begin
                bus_update(p);
                model_update();
                checks++; if (p != 1) $display("FAIL rnd_pulse it=%0d got=%0d exp=1", it, p); else passed++;
            end else begin
                case (sel)
                    1:       addr = 6'($urandom_range(4, 9));
                    2:       addr = 6'($urandom_range(29, 32));
                    default: addr = 6'($urandom_range(0, 63));
                endcase
                data = 8'($urandom_range(0, 255));
                bus_write(addr, data);
                model_write(int'(addr), data);
            end
            checks++; if (ftw1 !== exp_ftw()) $display("FAIL rnd_ftw it=%0d got=%h exp=%h", it, ftw1, exp_ftw()); else passed++;
            checks++; if (ctrl !== exp_ctrl()) $display("FAIL rnd_ctrl it=%0d got=%h exp=%h", it, ctrl, exp_ctrl()); else passed++;
            checks++; if (wr_cnt !== cnt_m) $display("FAIL rnd_cnt it=%0d got=%0d exp=%0d", it, wr_cnt, cnt_m); else passed++;
            checks++; if (wr_err !== err_m) $display("FAIL rnd_err it=%0d got=%b exp=%b", it, wr_err, err_m); else passed++;
        end
    endtask

`ifdef DDS_SLV_READBACK_EN
    task automatic test_readback();
        bus_write(6'h05, 8'h3C);
        model_write(5, 8'h3C);
        rd_addr = 6'h05;
        rd_sel = 1'b0;
        tick();
        checks++; if (rd_data !== sh_m[5]) $display("FAIL rb_shadow got=%h exp=%h", rd_data, sh_m[5]); else passed++;
        rd_sel = 1'b1;
        tick();
        checks++; if (rd_data !== act_m[5]) $display("FAIL rb_active got=%h exp=%h", rd_data, act_m[5]); else passed++;
        rd_addr = 6'h30;
        tick();
        checks++; if (rd_data !== 8'h00) $display("FAIL rb_range got=%h exp=00", rd_data); else passed++;
    endtask
`endif

    initial begin
        model_defaults();
        test_reset();
        test_ftw_update();
        test_ctrl();
        test_coincide();
        test_bad_addr();
        test_mst_rst();
        test_rst_held_high();
        test_cnt_wrap();
        test_random();
`ifdef DDS_SLV_READBACK_EN
        test_readback();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
